// File: rtl/scope_capture.sv
// Triggered min/max capture engine for the VGA scope path: decimates strobed samples into
// per-channel min/max bins held in a circular buffer, frozen around a level-crossing trigger.
//
// state | meaning
// IDLE  | no capture yet, waiting for arm
// PRE   | filling pre-trigger bins, crossings ignored
// WAIT  | circular writing, watching for a crossing
// POST  | writing bins after the trigger bin
// DONE  | buffer frozen, read port shows the capture
// ROLL  | free-running rolling display, never done
module scope_capture #(
    parameter int NCH   = 4,
    parameter int SW    = 12,
    parameter int DW    = 8,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ad_strobe,
    input  logic [NCH*SW-1:0]     ad_data,
    input  logic [15:0]           decim,
    input  logic [1:0]            trig_mode,
    input  logic [2:0]            trig_ch,
    input  logic [SW-1:0]         trig_level,
    input  logic [AW-1:0]         pretrig,
    input  logic                  arm,
    input  logic [AW-1:0]         rd_addr,
    output logic [NCH*2*DW-1:0]   rd_data,
    output logic [2:0]            state,
    output logic                  triggered,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4,
        S_ROLL = 3'd5
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    state_t st_q, st_d;

    logic [15:0]          decim_l, cnt, dec_eff;
    logic [1:0]           mode_l;
    logic [2:0]           ch_l;
    logic [SW-1:0]        level_l, prev, trig_smp;
    logic [AW-1:0]        pretrig_l, wr_ptr, trig_ptr, start_ptr, rd_idx;
    logic [AW:0]          bin_cnt, bin_nxt, post_len;
    logic                 prev_valid, running, arm_ok, smp_ok, bin_close;
    logic                 rise, fall, crossing;
    logic [SW-1:0]        run_min [NCH];
    logic [SW-1:0]        run_max [NCH];
    logic [SW-1:0]        new_min [NCH];
    logic [SW-1:0]        new_max [NCH];
    logic [NCH*2*DW-1:0]  wdata;
    logic [NCH*2*DW-1:0]  mem [DEPTH];

    always_comb begin
        dec_eff   = (decim_l == 16'd0) ? 16'd1 : decim_l;
        running   = st_q inside {S_PRE, S_WAIT, S_POST, S_ROLL};
        arm_ok    = arm && (st_q inside {S_IDLE, S_DONE, S_ROLL});
        // The arm cycle restarts binning, so a strobe coinciding with it is dropped.
        smp_ok    = ad_strobe && running && !arm_ok;
        bin_close = smp_ok && (cnt == dec_eff - 16'd1);
        bin_nxt   = bin_cnt + ONE_W;
        post_len  = DEPTH_W - {1'b0, pretrig_l};

        trig_smp = ad_data[SW-1:0];
        for (int c = 0; c < NCH; c++) begin
            if (ch_l == 3'(c)) trig_smp = ad_data[c*SW +: SW];
        end
        rise     = prev_valid && (prev < level_l) && (trig_smp >= level_l);
        fall     = prev_valid && (prev >= level_l) && (trig_smp < level_l);
        crossing = smp_ok && ((mode_l[0] && rise) || (mode_l[1] && fall));

        wdata = '0;
        for (int c = 0; c < NCH; c++) begin
            new_min[c] = (cnt == 16'd0 || ad_data[c*SW +: SW] < run_min[c]) ? ad_data[c*SW +: SW] : run_min[c];
            new_max[c] = (cnt == 16'd0 || ad_data[c*SW +: SW] > run_max[c]) ? ad_data[c*SW +: SW] : run_max[c];
            wdata[c*2*DW +: DW]      = new_min[c][SW-1 -: DW];
            wdata[c*2*DW + DW +: DW] = new_max[c][SW-1 -: DW];
        end

        case (st_q)
            S_IDLE:  start_ptr = '0;
            S_ROLL:  start_ptr = wr_ptr;
            default: start_ptr = trig_ptr - pretrig_l;
        endcase
        rd_idx = start_ptr + rd_addr;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            S_IDLE, S_DONE, S_ROLL: begin
                if (arm_ok) begin
                    if (trig_mode == 2'b00)       st_d = S_ROLL;
                    else if (pretrig == '0)       st_d = S_WAIT;
                    else                          st_d = S_PRE;
                end
            end
            S_PRE:  if (bin_close && bin_nxt == {1'b0, pretrig_l}) st_d = S_WAIT;
            // A crossing that also closes the only post bin completes the capture at once.
            S_WAIT: if (crossing) st_d = (bin_close && post_len == ONE_W) ? S_DONE : S_POST;
            S_POST: if (bin_close && bin_nxt == post_len) st_d = S_DONE;
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st_q <= S_IDLE;
        else       st_q <= st_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            decim_l    <= '0;
            mode_l     <= '0;
            ch_l       <= '0;
            level_l    <= '0;
            pretrig_l  <= '0;
            cnt        <= '0;
            bin_cnt    <= '0;
            wr_ptr     <= '0;
            trig_ptr   <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            triggered  <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                run_min[c] <= '0;
                run_max[c] <= '0;
            end
        end else if (arm_ok) begin
            decim_l    <= decim;
            mode_l     <= trig_mode;
            ch_l       <= trig_ch;
            level_l    <= trig_level;
            pretrig_l  <= pretrig;
            cnt        <= '0;
            bin_cnt    <= '0;
            wr_ptr     <= '0;
            trig_ptr   <= '0;
            prev_valid <= 1'b0;
            triggered  <= 1'b0;
        end else begin
            if (smp_ok) begin
                cnt        <= bin_close ? 16'd0 : cnt + 16'd1;
                prev       <= trig_smp;
                prev_valid <= 1'b1;
                for (int c = 0; c < NCH; c++) begin
                    run_min[c] <= new_min[c];
                    run_max[c] <= new_max[c];
                end
            end
            if (bin_close) wr_ptr <= wr_ptr + AW'(1);
            case (st_q)
                S_PRE:  if (bin_close) bin_cnt <= (st_d == S_WAIT) ? '0 : bin_nxt;
                S_WAIT: if (crossing) begin
                    bin_cnt   <= bin_close ? ONE_W : '0;
                    trig_ptr  <= wr_ptr;
                    triggered <= 1'b1;
                end
                S_POST: if (bin_close) bin_cnt <= bin_nxt;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (bin_close) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_data <= '0;
        else       rd_data <= mem[rd_idx];
    end

    assign state = st_q;
    assign done  = (st_q == S_DONE);

endmodule

// File: tb/tb_scope_capture.sv
// Bench for scope_capture: trigger-edge vector table, hand sequences for the capture corners,
// and randomized captures checked against a sample-history model of the capture rules.
module tb_scope_capture;

    localparam int NCH = 4, SW = 12, DW = 8, DEPTH = 16, AW = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         ad_strobe;
    logic [47:0]  ad_data;
    logic [15:0]  decim;
    logic [1:0]   trig_mode;
    logic [2:0]   trig_ch;
    logic [11:0]  trig_level;
    logic [3:0]   pretrig;
    logic         arm;
    logic [3:0]   rd_addr;
    logic [63:0]  rd_data;
    logic [2:0]   state;
    logic         triggered;
    logic         done;

    scope_capture #(.NCH(NCH), .SW(SW), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .ad_strobe(ad_strobe), .ad_data(ad_data), .decim(decim),
        .trig_mode(trig_mode), .trig_ch(trig_ch), .trig_level(trig_level), .pretrig(pretrig),
        .arm(arm), .rd_addr(rd_addr), .rd_data(rd_data), .state(state),
        .triggered(triggered), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model: configuration of the current capture plus every strobed sample since arm
    logic [1:0]  m_mode;
    int          m_ch, m_level, m_pt, m_dec;
    logic [11:0] hist [4][4096];
    int          nsmp = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [2:0]  ch;
        int          step_ch;
        logic [11:0] from_v;
        logic [11:0] to_v;
        logic        exp_trig;
    } vec_t;
    vec_t vt [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic feed(input logic [47:0] d);
        ad_strobe = 1'b1;
        ad_data   = d;
        for (int c = 0; c < 4; c++) hist[c][nsmp] = d[c*12 +: 12];
        if (nsmp < 4095) nsmp++;
        cycle();
        ad_strobe = 1'b0;
    endtask

    task automatic feed_ch(input int ch, input logic [11:0] v, input bit rnd);
        logic [47:0] d;
        d = rnd ? rnd48() : 48'd0;
        d[ch*12 +: 12] = v;
        feed(d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic do_arm(input logic [1:0] md, input logic [2:0] ch, input logic [11:0] lv,
                          input logic [3:0] pt, input logic [15:0] dc);
        trig_mode = md; trig_ch = ch; trig_level = lv; pretrig = pt; decim = dc;
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        m_mode = md;
        m_ch = (ch < 3'd4) ? int'(ch) : 0;
        m_level = int'(lv);
        m_pt = int'(pt);
        m_dec = (dc == 16'd0) ? 1 : int'(dc);
        nsmp = 0;
        // later changes must not disturb the latched configuration
        trig_mode = 2'($urandom); trig_ch = 3'($urandom); trig_level = 12'($urandom);
        pretrig = 4'($urandom); decim = 16'($urandom);
    endtask

    task automatic rd(input int a);
        rd_addr = 4'(a);
        cycle();
    endtask

    // index of the first sample that triggers, or -1
    function automatic int m_trig();
        int p, q;
        bit up, dn;
        if (m_mode == 2'b00) return -1;
        for (int i = 1; i < nsmp; i++) begin
            if (i / m_dec >= m_pt) begin
                p = int'(hist[m_ch][i-1]);
                q = int'(hist[m_ch][i]);
                up = (p < m_level) && (q >= m_level);
                dn = (p >= m_level) && (q < m_level);
                if (((m_mode == 2'b01 || m_mode == 2'b11) && up) ||
                    ((m_mode == 2'b10 || m_mode == 2'b11) && dn)) return i;
            end
        end
        return -1;
    endfunction

    // index of the sample that closes the last post-trigger bin
    function automatic int m_end(input int ti);
        return (ti / m_dec + DEPTH - m_pt) * m_dec - 1;
    endfunction

    function automatic logic [63:0] m_word(input int b);
        logic [63:0] w;
        logic [11:0] lo, hi, v;
        w = '0;
        for (int c = 0; c < 4; c++) begin
            lo = 12'hFFF; hi = 12'h000;
            for (int k = 0; k < m_dec; k++) begin
                v = hist[c][b*m_dec + k];
                if (v < lo) lo = v;
                if (v > hi) hi = v;
            end
            w[c*16 +: 8]     = lo[11:4];
            w[c*16 + 8 +: 8] = hi[11:4];
        end
        return w;
    endfunction

    task automatic check_display(input int base, input string tag);
        for (int x = 0; x < DEPTH; x++) begin
            rd(x);
            chk($sformatf("%s[%0d]", tag, x), rd_data, m_word(base + x));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int ti;
        bit fin;

        vt[0]  = '{2'd1, 3'd1, 1, 12'h100, 12'h900, 1'b1};
        vt[1]  = '{2'd1, 3'd1, 1, 12'h900, 12'h100, 1'b0};
        vt[2]  = '{2'd2, 3'd1, 1, 12'h900, 12'h100, 1'b1};
        vt[3]  = '{2'd2, 3'd1, 1, 12'h100, 12'h900, 1'b0};
        vt[4]  = '{2'd3, 3'd3, 3, 12'h100, 12'h900, 1'b1};
        vt[5]  = '{2'd3, 3'd3, 3, 12'h900, 12'h100, 1'b1};
        vt[6]  = '{2'd1, 3'd0, 0, 12'h7FF, 12'h800, 1'b1};
        vt[7]  = '{2'd1, 3'd0, 0, 12'h800, 12'hFFF, 1'b0};
        vt[8]  = '{2'd2, 3'd2, 2, 12'h800, 12'h7FF, 1'b1};
        vt[9]  = '{2'd2, 3'd2, 2, 12'hFFF, 12'h800, 1'b0};
        vt[10] = '{2'd1, 3'd5, 0, 12'h100, 12'h900, 1'b1};
        vt[11] = '{2'd1, 3'd1, 2, 12'h100, 12'h900, 1'b0};

        reset = 1'b1; ad_strobe = 1'b0; ad_data = '0; decim = 16'd1; trig_mode = 2'b00;
        trig_ch = 3'd0; trig_level = 12'h800; pretrig = 4'd0; arm = 1'b0; rd_addr = 4'd0;
        cycle(); cycle();
        chk("rst_state", state, 3'd0);
        chk("rst_trig", triggered, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd", rd_data, 64'd0);
        reset = 1'b0;
        cycle();

        // decimation by 4 of a ramp in rolling mode, then wrap past DEPTH bins
        do_arm(2'b00, 3'd0, 12'h800, 4'd0, 16'd4);
        chk("roll_state", state, 3'd5);
        for (int n = 0; n < 64; n++) feed_ch(0, 12'(n * 16), 1);
        for (int k = 0; k < DEPTH; k++) begin
            rd(k);
            chk($sformatf("ramp_ch0[%0d]", k), rd_data[15:0], {8'(4*k + 3), 8'(4*k)});
            chk($sformatf("ramp_all[%0d]", k), rd_data, m_word(k));
        end
        for (int n = 64; n < 80; n++) feed_ch(0, 12'(n * 16), 1);
        rd(0);
        chk("roll_wrap_bin4", rd_data[15:0], 16'h1310);
        check_display(nsmp / m_dec - DEPTH, "roll_disp");
        chk("roll_done", done, 1'b0);

        // single-sample spike mid-bin, armed again from ROLL
        do_arm(2'b00, 3'd0, 12'h800, 4'd0, 16'd8);
        for (int n = 0; n < 128; n++) feed_ch(2, (n == 43) ? 12'hFFF : 12'h400, 1);
        rd(4); chk("glitch_max4", rd_data[47:40], 8'h40);
        rd(5); chk("glitch_max5", rd_data[47:40], 8'hFF);
        chk("glitch_min5", rd_data[39:32], 8'h40);
        rd(6); chk("glitch_max6", rd_data[47:40], 8'h40);
        check_display(0, "glitch_disp");

        // rising trigger with pretrig 4; PRE crossing and POST arm are both ignored
        do_reset();
        do_arm(2'b01, 3'd1, 12'h800, 4'd4, 16'd1);
        for (int i = 0; i < 41; i++) begin
            feed_ch(1, (i == 1) ? 12'h900 : ((i < 20) ? 12'h100 : 12'h900), 1);
            if (i == 1)  begin chk("pre_state", state, 3'd1); chk("pre_trig", triggered, 1'b0); end
            if (i == 19) begin chk("wait_state", state, 3'd2); chk("wait_trig", triggered, 1'b0); end
            if (i == 20) begin chk("rise_trig", triggered, 1'b1); chk("rise_state", state, 3'd3); end
            if (i == 25) begin
                trig_mode = 2'b00; arm = 1'b1; cycle(); arm = 1'b0;
                chk("post_arm_state", state, 3'd3);
            end
            if (i == 30) chk("rise_done30", done, 1'b0);
            if (i == 31) begin chk("rise_done31", done, 1'b1); chk("rise_state31", state, 3'd4); end
        end
        rd(4); chk("rise_rd4", rd_data[31:16], 16'h9090);
        rd(3); chk("rise_rd3", rd_data[31:16], 16'h1010);
        check_display(m_trig() / m_dec - m_pt, "rise_disp");

        // falling trigger, pretrig 0, decim 0 acting as 1, armed from DONE
        do_arm(2'b10, 3'd0, 12'h800, 4'd0, 16'd0);
        chk("fall_state", state, 3'd2);
        for (int i = 0; i < 26; i++) begin
            feed_ch(0, (i < 7) ? 12'h900 : 12'h100, 1);
            if (i == 6)  chk("fall_trig6", triggered, 1'b0);
            if (i == 7)  begin chk("fall_trig7", triggered, 1'b1); chk("fall_state7", state, 3'd3); end
            if (i == 21) chk("fall_done21", done, 1'b0);
            if (i == 22) chk("fall_done22", done, 1'b1);
        end
        rd(0); chk("fall_rd0", rd_data[15:0], 16'h1010);
        check_display(7, "fall_disp");

        // the first sample after arm cannot trigger, even though the old previous sample was low
        do_arm(2'b01, 3'd0, 12'h800, 4'd0, 16'd1);
        feed_ch(0, 12'h900, 0);
        chk("first_smp_trig", triggered, 1'b0);
        feed_ch(0, 12'h100, 0);
        feed_ch(0, 12'h900, 0);
        chk("second_cross_trig", triggered, 1'b1);

        // pretrig DEPTH-1: the crossing bin is the only post bin
        do_reset();
        do_arm(2'b01, 3'd0, 12'h800, 4'd15, 16'd1);
        for (int i = 0; i < 17; i++) feed_ch(0, (i < 16) ? 12'h100 : 12'h900, 1);
        chk("pt15_done", done, 1'b1);
        chk("pt15_trig", triggered, 1'b1);
        check_display(1, "pt15_disp");
        #2 reset = 1'b1;
        #1 chk("rst_done_async", done, 1'b0);
        cycle(); reset = 1'b0;

        // asynchronous reset in POST, checked before any clock edge
        do_arm(2'b01, 3'd1, 12'h800, 4'd2, 16'd1);
        for (int i = 0; i < 6; i++) feed_ch(1, (i < 5) ? 12'h100 : 12'h900, 1);
        chk("rstpost_pre", state, 3'd3);
        #2 reset = 1'b1;
        #1;
        chk("rstpost_state", state, 3'd0);
        chk("rstpost_done", done, 1'b0);
        chk("rstpost_trig", triggered, 1'b0);
        chk("rstpost_rd", rd_data, 64'd0);
        cycle(); reset = 1'b0;

        // edge-detection table
        for (int v = 0; v < 12; v++) begin
            do_reset();
            do_arm(vt[v].mode, vt[v].ch, 12'h800, 4'd0, 16'd1);
            for (int k = 0; k < 3; k++) feed_ch(vt[v].step_ch, vt[v].from_v, 0);
            feed_ch(vt[v].step_ch, vt[v].to_v, 0);
            chk($sformatf("vec%0d_trig", v), triggered, vt[v].exp_trig);
            chk($sformatf("vec%0d_state", v), state, vt[v].exp_trig ? 3'd3 : 3'd2);
        end

        // randomized captures against the model
        for (int it = 0; it < 6; it++) begin
            do_reset();
            do_arm(2'($urandom_range(1, 3)), 3'($urandom_range(0, 7)), 12'($urandom_range(256, 3840)),
                   4'($urandom_range(0, 15)), 16'($urandom_range(0, 3)));
            fin = 1'b0;
            ti = -1;
            for (int n = 0; n < 400 && !fin; n++) begin
                if ($urandom_range(0, 3) == 0) cycle();
                feed(rnd48());
                ti = m_trig();
                chk($sformatf("rnd%0d_trig", it), triggered, ti >= 0);
                fin = (ti >= 0) && ((nsmp - 1) >= m_end(ti));
                chk($sformatf("rnd%0d_done", it), done, fin);
            end
            if (fin) check_display(ti / m_dec - m_pt, $sformatf("rnd%0d_disp", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scope_capture.md
# scope_capture

Parametrised multi-channel triggered capture engine for the VGA scope path. Decimates a strobed ADC sample stream into per-channel min/max bins, stores them in a circular on-chip buffer, and freezes the buffer around a level-crossing trigger with a programmable pre-trigger depth. A single-cycle-latency read port returns bins in display order, so the VGA renderer reads pixel column x as bin x with no address arithmetic.

## Interface
- NCH, 4: channel count (1..8)
- SW, 12: ADC sample width
- DW, 8: stored width per min/max value; the top DW bits of the sample (SW >= DW)
- DEPTH, 1024: bins in the buffer; must be a power of 2
- AW, $clog2(DEPTH): bin address width
- clk  in  1  system clock; the only clock
- reset  in  1  reset, asynchronous, active-high
- ad_strobe  in  1  sample valid qualifier
- ad_data  in  NCH*SW  samples; channel c occupies [c*SW +: SW]
- decim  in  16  samples per bin; 0 is treated as 1
- trig_mode  in  2  00 rolling, 01 rising, 10 falling, 11 either edge
- trig_ch  in  3  trigger channel index; values >= NCH select channel 0
- trig_level  in  SW  trigger threshold
- pretrig  in  AW  number of bins kept before the trigger bin
- arm  in  1  single-cycle pulse that starts a capture
- rd_addr  in  AW  display-order bin index; 0 is the oldest bin
- rd_data  out  NCH*2*DW  channel c: max at [c*2*DW+DW +: DW], min at [c*2*DW +: DW]
- state  out  3  FSM state: 0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE, 5 ROLL
- triggered  out  1  trigger seen in the current capture
- done  out  1  capture complete and buffer frozen

## Operation
- decim, trig_*, and pretrig are latched on an accepted arm. Changes at any other time have no effect.
- **Binning**
  - A sample counter counts strobes, 0..decim_l-1.
  - At count 0, each channel's running min and max load the current sample.
  - On later counts, each compares unsigned against the sample: min keeps the smaller value, max the larger.
  - The strobe at count decim_l-1 closes the bin. The merged min/max (including that sample), truncated to the top DW bits, is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- **Trigger detect**
  - Compares the previous and current strobed sample of the selected channel (unsigned).
  - Rising: prev < level and cur >= level.
  - Falling: prev >= level and cur < level.
  - The "previous sample" register reloads on arm, so the first sample after arm cannot trigger.
- **FSM**
  - IDLE: wait for arm. Arm with mode 00 goes to ROLL; any other mode goes to PRE, or straight to WAIT if pretrig is 0. Arm clears wr_ptr, the bin counters, triggered, and done.
  - PRE: leave for WAIT after pretrig bins have been written. Crossings during PRE are ignored.
  - WAIT: keep writing bins (circular overwrite). On a crossing, go to POST and set triggered. The bin containing the crossing sample is the trigger bin: trig_ptr = wr_ptr at that moment.
  - POST: after DEPTH-pretrig bins have been written (counting from and including the trigger bin), stop writing and go to DONE. Start pointer is start_ptr = trig_ptr - pretrig mod DEPTH.
  - DONE: buffer frozen and done = 1. Arm restarts exactly as it does from IDLE.
  - ROLL: free-running, never done. start_ptr = wr_ptr, so the oldest bin always displays at x = 0. Arm re-latches the configuration. Trigger crossings are ignored.
  - Arm in PRE, WAIT, or POST is ignored.
- **Read:** memory address = start_ptr + rd_addr mod DEPTH. In IDLE, start_ptr = 0.

## Timing
- Reset values:
  - state = IDLE; wr_ptr, counters, start_ptr, triggered, done = 0.
  - rd_data = 0 until the first read clock edge after reset deasserts.
  - Buffer contents are undefined.
- ad_strobe may be high on every cycle with no loss. The bin write occurs on the clock edge that registers the closing strobe.
- The trigger is evaluated on the strobe edge. triggered and state = POST are visible the cycle after the crossing strobe.
- done rises the cycle after the final POST bin write. No bin is written after done.
- rd_data is registered: data for rd_addr presented in cycle n is valid in cycle n+1.
- Read and write in the same cycle at the same address return the old data.
- Reset asserted mid-capture aborts immediately to IDLE. The buffer is not cleared.
- wr_ptr wrap (DEPTH-1 to 0) is seamless in all states.

## Test plan
1. **Decimation.** NCH=4, DEPTH=16, decim=4, mode 00, ramp 0,16,32,... on channel 0 → bin k holds min=(64k)>>4 and max=(64k+48)>>4.
2. **Rising trigger.** decim=1, pretrig=4, level=0x800, channel 1 steps 0x100→0x900 at sample 20 → triggered the cycle after sample 20; done after 12 post bins; rd_addr 4 returns 0x90 as both max and min.
3. **Falling trigger, pretrig=0.** Arm → state = WAIT directly. A 0x900→0x100 step at sample 7 triggers; rd_addr 0 = trigger bin = 0x10.
4. **Glitch capture.** decim=8, a single-sample 0xFFF spike on channel 2 mid-bin → that bin's max = 0xFF; neighbouring bins' max = baseline.
5. **Ignored events.**
   - A crossing during PRE → no trigger.
   - Arm during POST → ignored; capture completes.
   - decim=0 behaves as decim=1.
6. **Reset and rolling wrap.** Async reset in POST → state = IDLE and done = 0 with no clock edge required. In rolling mode after 20 bins with DEPTH=16 → rd_addr 0 returns bin 4.
